// File: rtl/qev_pseudo_packet_gen.sv
// qev_pseudo_packet_gen
// Generates pseudo event packets for bring-up of the USB readout path without
// a fiber link. Words are presented with first-word-fall-through semantics so
// the USB slave-FIFO engine can pull them as if from a packet FIFO.
// Packet: HEADER, event[31:16], event[15:0], length, payload..., checksum, TRAILER.

module qev_pseudo_packet_gen #(
  parameter int          PAYLOAD_WORDS = 64,
  parameter int          GAP_CYCLES    = 16,
  parameter logic [15:0] HEADER_WORD   = 16'h00BE,
  parameter logic [15:0] TRAILER_WORD  = 16'h00EF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        continuous,
  input  logic        trig,
  input  logic        qev_tx_rd_en,
  output logic [15:0] qev_tx_data,
  output logic        qev_tx_empty,
  output logic [31:0] event_number,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE,
    GAP,
    HDR,
    EVH,
    EVL,
    LEN,
    PAY,
    CSUM,
    TRL
  } state_t;

  // Payload index of the last payload word and the packet length word.
  localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_WORDS - 1);
  localparam logic [15:0] LEN_WORD = 16'(PAYLOAD_WORDS);

  // The gap counter counts down to zero, so it is loaded with one less than
  // the number of empty cycles wanted between trailer and next header.
  localparam logic [31:0] GAP_LOAD = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
  localparam bit          HAS_GAP  = (GAP_CYCLES > 0);

  state_t      state;
  logic [15:0] csum;
  logic [15:0] pay_idx;
  logic [31:0] gap_cnt;
  logic        pending;

  logic        accept;
  logic        start_pkt;
  logic [15:0] csum_sum;
  logic        trl_done;
  logic        restart_now;

  // Handshake decode and the single point where a new packet is launched.
  always_comb begin
    accept      = qev_tx_rd_en & ~qev_tx_empty;
    csum_sum    = csum + qev_tx_data;
    trl_done    = (state == TRL) && accept;
    restart_now = trl_done && continuous && enable && !HAS_GAP;
    start_pkt   = 1'b0;
    case (state)
      IDLE:    start_pkt = enable && (continuous || trig || pending);
      GAP:     start_pkt = enable && (gap_cnt == 32'd0);
      TRL:     start_pkt = restart_now;
      default: start_pkt = 1'b0;
    endcase
  end

  // One-deep trigger memory: a trig arriving while a packet is in flight
  // schedules exactly one follow-up packet; extra trigs are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (start_pkt) begin
      pending <= 1'b0;
    end else if (trig && enable && (state != IDLE)) begin
      pending <= 1'b1;
    end
  end

  // Packet sequencer with registered FWFT outputs; every emitting state
  // moves on only when its word is accepted by the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      qev_tx_data  <= 16'h0000;
      qev_tx_empty <= 1'b1;
      event_number <= 32'h0000_0000;
      busy         <= 1'b0;
      csum         <= 16'h0000;
      pay_idx      <= 16'h0000;
      gap_cnt      <= 32'h0000_0000;
    end else begin
      if (trl_done) begin
        event_number <= event_number + 32'd1;
      end

      if (start_pkt) begin
        state        <= HDR;
        qev_tx_data  <= HEADER_WORD;
        qev_tx_empty <= 1'b0;
        busy         <= 1'b1;
        csum         <= 16'h0000;
      end else begin
        case (state)
          IDLE: begin
            qev_tx_empty <= 1'b1;
            busy         <= 1'b0;
          end

          GAP: begin
            if (!enable) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - 32'd1;
            end
          end

          HDR: begin
            if (accept) begin
              state       <= EVH;
              qev_tx_data <= event_number[31:16];
              csum        <= csum_sum;
            end
          end

          EVH: begin
            if (accept) begin
              state       <= EVL;
              qev_tx_data <= event_number[15:0];
              csum        <= csum_sum;
            end
          end

          EVL: begin
            if (accept) begin
              state       <= LEN;
              qev_tx_data <= LEN_WORD;
              csum        <= csum_sum;
            end
          end

          LEN: begin
            if (accept) begin
              state       <= PAY;
              qev_tx_data <= event_number[15:0];
              pay_idx     <= 16'h0000;
              csum        <= csum_sum;
            end
          end

          PAY: begin
            if (accept) begin
              csum <= csum_sum;
              if (pay_idx == LAST_IDX) begin
                state       <= CSUM;
                qev_tx_data <= csum_sum;
              end else begin
                pay_idx     <= pay_idx + 16'd1;
                qev_tx_data <= qev_tx_data + 16'd1;
              end
            end
          end

          CSUM: begin
            if (accept) begin
              state       <= TRL;
              qev_tx_data <= TRAILER_WORD;
            end
          end

          TRL: begin
            if (accept) begin
              qev_tx_empty <= 1'b1;
              if (continuous && enable) begin
                state   <= GAP;
                gap_cnt <= GAP_LOAD;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end

          default: begin
            state        <= IDLE;
            qev_tx_empty <= 1'b1;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qev_pseudo_packet_gen.sv
// tb_qev_pseudo_packet_gen
// Directed bench for the pseudo packet generator. One instance uses a 3-cycle
// inter-packet gap, a second uses no gap. Expected packet words are written
// out by hand for each event number used.

module tb_qev_pseudo_packet_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        en0;
  logic        continuous;
  logic        trig;
  logic        rdEn;

  logic [15:0] dataGap;
  logic        emptyGap;
  logic [31:0] evGap;
  logic        busyGap;
  logic [15:0] dataNoGap;
  logic        emptyNoGap;
  logic [31:0] evNoGap;
  logic        busyNoGap;

  logic        useNoGap;
  logic [15:0] obsData;
  logic        obsEmpty;
  logic [31:0] obsEv;
  logic        obsBusy;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expWords [10];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  assign obsData  = useNoGap ? dataNoGap  : dataGap;
  assign obsEmpty = useNoGap ? emptyNoGap : emptyGap;
  assign obsEv    = useNoGap ? evNoGap    : evGap;
  assign obsBusy  = useNoGap ? busyNoGap  : busyGap;

  qev_pseudo_packet_gen #(
    .PAYLOAD_WORDS(4),
    .GAP_CYCLES   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (en),
    .continuous  (continuous),
    .trig        (trig),
    .qev_tx_rd_en(rdEn),
    .qev_tx_data (dataGap),
    .qev_tx_empty(emptyGap),
    .event_number(evGap),
    .busy        (busyGap)
  );

  qev_pseudo_packet_gen #(
    .PAYLOAD_WORDS(4),
    .GAP_CYCLES   (0)
  ) dutNoGap (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (en0),
    .continuous  (continuous),
    .trig        (trig),
    .qev_tx_rd_en(rdEn),
    .qev_tx_data (dataNoGap),
    .qev_tx_empty(emptyNoGap),
    .event_number(evNoGap),
    .busy        (busyNoGap)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, observed, expected);
    end
  endtask

  // One-cycle trig pulse; returns at the falling edge after the sampling edge.
  task automatic applyStimulus();
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  // Pull one 10-word packet from the selected instance and compare every word
  // that is visible, both while held and when accepted. Optionally stalls the
  // consumer at random, and optionally drops enable at a given word index.
  task automatic readPacket(input string tag, input bit stall, input int dropAt);
    int  idx    = 0;
    int  cycles = 0;
    logic take;
    while (idx < 10 && cycles < 300) begin
      take = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (idx == dropAt) begin
        en  = 1'b0;
        en0 = 1'b0;
      end
      if (!obsEmpty) begin
        checkOutput($sformatf("%s word%0d", tag, idx), 32'(obsData), 32'(expWords[idx]));
        if (take) idx++;
      end else if (idx > 0 && !stall) begin
        checkOutput($sformatf("%s bubble at word%0d", tag, idx), 32'(obsEmpty), 32'd0);
      end
      rdEn = take;
      @(negedge clk);
      cycles++;
    end
    if (idx < 10) begin
      checkOutput({tag, " timeout"}, 32'(idx), 32'd10);
    end
  endtask

  initial begin
    int gapCount;

    rst_n      = 1'b0;
    en         = 1'b0;
    en0        = 1'b0;
    continuous = 1'b0;
    trig       = 1'b0;
    rdEn       = 1'b0;
    useNoGap   = 1'b0;

    #12;
    checkOutput("reset empty", 32'(obsEmpty), 32'd1);
    checkOutput("reset data", 32'(obsData), 32'd0);
    checkOutput("reset event", obsEv, 32'd0);
    checkOutput("reset busy", 32'(obsBusy), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Triggered packet, event 0, consumer always ready.
    applyStimulus();
    checkOutput("ev0 header latency", 32'(obsEmpty), 32'd0);
    expWords = '{16'h00BE, 16'h0000, 16'h0000, 16'h0004, 16'h0000,
                 16'h0001, 16'h0002, 16'h0003, 16'h00C8, 16'h00EF};
    readPacket("ev0", 1'b0, -1);
    checkOutput("ev0 empty after", 32'(obsEmpty), 32'd1);
    checkOutput("ev0 event after", obsEv, 32'd1);
    checkOutput("ev0 busy after", 32'(obsBusy), 32'd0);
    rdEn = 1'b0;

    // Second trig, event 1.
    applyStimulus();
    expWords = '{16'h00BE, 16'h0000, 16'h0001, 16'h0004, 16'h0001,
                 16'h0002, 16'h0003, 16'h0004, 16'h00CD, 16'h00EF};
    readPacket("ev1", 1'b0, -1);
    rdEn = 1'b0;

    // Event 2 with a randomly stalling consumer.
    applyStimulus();
    expWords = '{16'h00BE, 16'h0000, 16'h0002, 16'h0004, 16'h0002,
                 16'h0003, 16'h0004, 16'h0005, 16'h00D2, 16'h00EF};
    readPacket("ev2 stalled", 1'b1, -1);
    rdEn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("ev2 event after", obsEv, 32'd3);

    // Three trigs while event 3 waits in its header: exactly one extra packet.
    applyStimulus();
    applyStimulus();
    applyStimulus();
    applyStimulus();
    expWords = '{16'h00BE, 16'h0000, 16'h0003, 16'h0004, 16'h0003,
                 16'h0004, 16'h0005, 16'h0006, 16'h00D7, 16'h00EF};
    readPacket("ev3", 1'b0, -1);
    expWords = '{16'h00BE, 16'h0000, 16'h0004, 16'h0004, 16'h0004,
                 16'h0005, 16'h0006, 16'h0007, 16'h00DC, 16'h00EF};
    readPacket("ev4 pending", 1'b0, -1);
    repeat (20) @(negedge clk);
    checkOutput("one extra empty", 32'(obsEmpty), 32'd1);
    checkOutput("one extra event", obsEv, 32'd5);
    checkOutput("one extra busy", 32'(obsBusy), 32'd0);
    rdEn = 1'b0;

    // Enable dropped in the middle of the payload: packet still completes.
    applyStimulus();
    expWords = '{16'h00BE, 16'h0000, 16'h0005, 16'h0004, 16'h0005,
                 16'h0006, 16'h0007, 16'h0008, 16'h00E1, 16'h00EF};
    readPacket("ev5 enable drop", 1'b0, 5);
    checkOutput("enable drop busy", 32'(obsBusy), 32'd0);
    checkOutput("enable drop empty", 32'(obsEmpty), 32'd1);
    checkOutput("enable drop event", obsEv, 32'd6);
    applyStimulus();
    @(negedge clk);
    checkOutput("trig while disabled empty", 32'(obsEmpty), 32'd1);
    checkOutput("trig while disabled busy", 32'(obsBusy), 32'd0);
    rdEn = 1'b0;

    // Continuous mode with a 3-cycle gap.
    @(negedge clk);
    continuous = 1'b1;
    en         = 1'b1;
    @(negedge clk);
    checkOutput("cont header latency", 32'(obsEmpty), 32'd0);
    expWords = '{16'h00BE, 16'h0000, 16'h0006, 16'h0004, 16'h0006,
                 16'h0007, 16'h0008, 16'h0009, 16'h00E6, 16'h00EF};
    readPacket("ev6 cont", 1'b0, -1);
    gapCount = 0;
    while (obsEmpty && gapCount < 20) begin
      gapCount++;
      @(negedge clk);
    end
    checkOutput("gap3 length", 32'(gapCount), 32'd3);
    expWords = '{16'h00BE, 16'h0000, 16'h0007, 16'h0004, 16'h0007,
                 16'h0008, 16'h0009, 16'h000A, 16'h00EB, 16'h00EF};
    readPacket("ev7 cont", 1'b0, -1);
    en         = 1'b0;
    continuous = 1'b0;
    rdEn       = 1'b0;
    @(negedge clk);
    checkOutput("gap abort busy", 32'(obsBusy), 32'd0);
    checkOutput("gap abort empty", 32'(obsEmpty), 32'd1);
    checkOutput("gap abort event", obsEv, 32'd8);

    // Continuous mode with no gap on the second instance.
    useNoGap   = 1'b1;
    continuous = 1'b1;
    en0        = 1'b1;
    @(negedge clk);
    expWords = '{16'h00BE, 16'h0000, 16'h0000, 16'h0004, 16'h0000,
                 16'h0001, 16'h0002, 16'h0003, 16'h00C8, 16'h00EF};
    readPacket("nogap ev0", 1'b0, -1);
    checkOutput("gap0 empty", 32'(obsEmpty), 32'd0);
    checkOutput("gap0 data", 32'(obsData), 32'h00BE);
    expWords = '{16'h00BE, 16'h0000, 16'h0001, 16'h0004, 16'h0001,
                 16'h0002, 16'h0003, 16'h0004, 16'h00CD, 16'h00EF};
    readPacket("nogap ev1", 1'b0, 2);
    checkOutput("nogap stop busy", 32'(obsBusy), 32'd0);
    checkOutput("nogap stop event", obsEv, 32'd2);
    useNoGap   = 1'b0;
    continuous = 1'b0;
    rdEn       = 1'b0;

    // Event number wrap, starting from a forced all-ones event number.
    en = 1'b1;
    @(negedge clk);
    force dut.event_number = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.event_number;
    @(negedge clk);
    checkOutput("wrap preset", obsEv, 32'hFFFF_FFFF);
    applyStimulus();
    expWords = '{16'h00BE, 16'hFFFF, 16'hFFFF, 16'h0004, 16'hFFFF,
                 16'h0000, 16'h0001, 16'h0002, 16'h00C2, 16'h00EF};
    readPacket("evFFFFFFFF", 1'b0, -1);
    checkOutput("wrap event after", obsEv, 32'd0);
    rdEn = 1'b0;
    applyStimulus();
    expWords = '{16'h00BE, 16'h0000, 16'h0000, 16'h0004, 16'h0000,
                 16'h0001, 16'h0002, 16'h0003, 16'h00C8, 16'h00EF};
    readPacket("wrapped ev0", 1'b0, -1);
    rdEn = 1'b0;

    // Asynchronous reset while in the payload of event 1.
    applyStimulus();
    rdEn = 1'b1;
    repeat (6) @(negedge clk);
    rdEn = 1'b0;
    checkOutput("pre-reset busy", 32'(obsBusy), 32'd1);
    checkOutput("pre-reset payload", 32'(obsData), 32'h0003);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset empty", 32'(obsEmpty), 32'd1);
    checkOutput("async reset data", 32'(obsData), 32'd0);
    checkOutput("async reset event", obsEv, 32'd0);
    checkOutput("async reset busy", 32'(obsBusy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus();
    readPacket("post-reset ev0", 1'b0, -1);
    rdEn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/qev_pseudo_packet_gen.md
Name: qev_pseudo_packet_gen

Overview:
- Generates pseudo event packets of 16-bit words for fiber-less bring-up of the USB readout path.
- Sits directly upstream of the USB top-level packet port and drives its QEV_TX data/empty/read-enable handshake.
- Presents first-word-fall-through (FWFT) FIFO semantics, so the USB slave-FIFO engine pulls words as if from a packet FIFO.
- Runs in continuous or triggered mode, with a running 32-bit event number and a per-packet checksum.

Parameters:
- PAYLOAD_WORDS, 64: payload words per packet. Legal range 1..65535.
- GAP_CYCLES, 16: idle cycles between packets in continuous mode. 0 is legal.
- HEADER_WORD, 16'h00BE: first word of every packet.
- TRAILER_WORD, 16'h00EF: last word of every packet.

Ports:
- clk  input  1  USB FIFO clock (locked IFCLK domain). Sole clock.
- rst_n  input  1  Asynchronous, active-low reset.
- enable  input  1  Level. Permits packet generation.
- continuous  input  1  1 = free-running packets; 0 = one packet per trig.
- trig  input  1  Single-cycle request; used when continuous=0.
- qev_tx_rd_en  input  1  Consumer read strobe. Feeds QEV_TX_RD_EN.
- qev_tx_data  output  16  Current word. Feeds QEV_TX_DATA_BUS.
- qev_tx_empty  output  1  1 = no word available. Feeds QEV_TX_EMPTY.
- event_number  output  32  Event number of the current/next packet.
- busy  output  1  1 while a packet is being presented or in gap.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - qev_tx_empty=1, qev_tx_data=0, event_number=0, busy=0.
  - State=IDLE; checksum accumulator=0; pending flag=0.
- Packet format, PAYLOAD_WORDS+6 words:
  - HEADER_WORD, event_number[31:16], event_number[15:0], PAYLOAD_WORDS[15:0].
  - Payload word i (i=0..N-1) = event_number[15:0]+i, mod 2^16.
  - CHECKSUM = mod-2^16 sum of all preceding words of the packet.
  - TRAILER_WORD.
- FWFT handshake:
  - While qev_tx_empty=0, qev_tx_data holds the current word.
  - A word is accepted at a rising edge with qev_tx_rd_en=1 and qev_tx_empty=0.
  - The next word appears in the following cycle, with no bubbles inside a packet, so back-to-back rd_en streams one word per cycle.
  - qev_tx_rd_en while empty=1 is ignored: no state change.
  - Output registers only; no combinational path from rd_en to data or empty.
- States: IDLE, GAP, HDR, EVH, EVL, LEN, PAY, CSUM, TRL.
  - Each emitting state advances only on an accepted word. PAY loops on a 16-bit index until index=PAYLOAD_WORDS-1.
  - The checksum accumulator clears on entry to HDR and adds each accepted word from HDR through the last PAY word.
- IDLE -> HDR when enable=1 and either (continuous=1) or (trig=1 or pending=1):
  - Header is visible (empty=0) in the cycle after that edge.
  - pending clears on packet start.
- TRL accepted:
  - event_number increments, wrapping 32'hFFFFFFFF -> 0.
  - If continuous=1, enable=1 and GAP_CYCLES>0: go to GAP for exactly GAP_CYCLES cycles with empty=1, then HDR.
  - If continuous=1, enable=1 and GAP_CYCLES=0: go straight to HDR, header in the next cycle.
  - Otherwise: go to IDLE.
- trig while busy sets pending; further trigs while pending=1 are dropped (one-deep). trig with enable=0 is ignored.
- enable deasserted mid-packet: the current packet completes to TRL, then IDLE; GAP is aborted to IDLE.
- Mode change mid-packet takes effect at the next packet decision.
- busy=1 in every state except IDLE. empty=1 in IDLE and GAP.

Test Plan:
- Reset mid-packet: assert rst_n=0 while in PAY -> empty=1, data=0, event_number=0 immediately. After release, a trig yields a header with event 0.
- Triggered, PAYLOAD_WORDS=4, continuous rd_en:
  - trig -> words 00BE,0000,0000,0004,0000,0001,0002,0003,00C8,00EF on consecutive cycles.
  - Then empty=1 and event_number=1.
- Second trig (event 1) -> payload 0001..0004, checksum 00CD.
- Stalled consumer: rd_en toggled randomly -> identical word sequence, each word held until accepted, no duplicates or skips.
- Continuous mode, GAP_CYCLES=3 -> exactly 3 empty cycles between trailer acceptance and next header. GAP_CYCLES=0 -> zero empty cycles.
- Three trigs during a packet -> exactly one extra packet follows. Separately, enable drop mid-payload -> packet finishes, then IDLE.
- Wrap: event_number preset via 2^32-1 packets (forced) -> next packet carries FFFF/FFFF, following packet carries 0000/0000.
